// File: rtl/uart_byte_ctrl.sv
// uart_byte_ctrl: byte FIFOs plus start/clear sequencing between a CPU MMIO port and an async UART transmitter/receiver.
// Ports: clk, rst_n (sync, active-low); tx_in_* CPU->TX FIFO stream; rx_out_* RX FIFO->CPU stream (data combinational
// from storage); txd_start/txd_data/txd_busy transmitter handshake; rxd_ready/rxd_data/rxd_clear receiver handshake;
// tx_count/rx_count occupancy; rx_overrun sticky drop flag with overrun_clr.
// Build option: UART_BYTE_CTRL_LOOPBACK_EN adds input loopback, which routes TX FIFO bytes straight into the RX FIFO.
module uart_byte_ctrl #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef UART_BYTE_CTRL_LOOPBACK_EN
  input  logic                        loopback,
`endif
  input  logic                        tx_in_valid,
  output logic                        tx_in_ready,
  input  logic [7:0]                  tx_in_data,
  output logic                        rx_out_valid,
  input  logic                        rx_out_ready,
  output logic [7:0]                  rx_out_data,
  output logic                        txd_start,
  output logic [7:0]                  txd_data,
  input  logic                        txd_busy,
  input  logic                        rxd_ready,
  input  logic [7:0]                  rxd_data,
  output logic                        rxd_clear,
  output logic [$clog2(TX_DEPTH):0]   tx_count,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic                        rx_overrun,
  input  logic                        overrun_clr
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
  state_t     state_q;
  logic       lb;
`ifdef UART_BYTE_CTRL_LOOPBACK_EN
  assign lb = loopback;
`else
  assign lb = 1'b0;
`endif
  logic [7:0] tx_mem_q [TX_DEPTH];
  logic [7:0] rx_mem_q [RX_DEPTH];
  logic [TAW:0] tx_wp_q, tx_rp_q, tx_wp_d, tx_rp_d;
  logic [RAW:0] rx_wp_q, rx_rp_q, rx_wp_d, rx_rp_d;
  logic       tx_empty, tx_full, tx_push, tx_pop, rx_full, rx_pop, rx_in, rx_push, rx_drop, capture;
  logic [7:0] tx_head, rx_wdata;
  logic       rx_overrun_d;
  // Pointers carry one extra wrap bit: equal means empty, equal index with differing wrap bit means full.
  assign tx_empty    = tx_wp_q == tx_rp_q;
  assign tx_full     = tx_wp_q == {~tx_rp_q[TAW], tx_rp_q[TAW-1:0]};
  assign tx_in_ready = !tx_full;
  assign tx_push     = tx_in_valid && !tx_full;
  // In loopback the transmitter is bypassed, so its busy flag is irrelevant.
  assign tx_pop      = state_q == IDLE && !tx_empty && (lb || !txd_busy);
  assign tx_head     = tx_mem_q[tx_rp_q[TAW-1:0]];
  assign tx_wp_d     = tx_wp_q + (TAW+1)'(tx_push);
  assign tx_rp_d     = tx_rp_q + (TAW+1)'(tx_pop);
  assign tx_count    = tx_wp_q - tx_rp_q;
  // rxd_ready is still high in the cycle our clear pulse is out, so skip that cycle to avoid a double capture.
  assign capture      = rxd_ready && !rxd_clear && !lb;
  assign rx_full      = rx_wp_q == {~rx_rp_q[RAW], rx_rp_q[RAW-1:0]};
  assign rx_out_valid = rx_wp_q != rx_rp_q;
  assign rx_out_data  = rx_mem_q[rx_rp_q[RAW-1:0]];
  assign rx_pop       = rx_out_valid && rx_out_ready;
  assign rx_in        = capture || (tx_pop && lb);
  assign rx_wdata     = lb ? tx_head : rxd_data;
  // A full FIFO still accepts when the head is being popped in the same cycle.
  assign rx_push      = rx_in && (!rx_full || rx_pop);
  assign rx_drop      = rx_in && !rx_push;
  assign rx_wp_d      = rx_wp_q + (RAW+1)'(rx_push);
  assign rx_rp_d      = rx_rp_q + (RAW+1)'(rx_pop);
  assign rx_count     = rx_wp_q - rx_rp_q;
  assign rx_overrun_d = rx_drop || (rx_overrun && !overrun_clr);
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q[TAW-1:0]] <= tx_in_data;
    if (rx_push) rx_mem_q[rx_wp_q[RAW-1:0]] <= rx_wdata;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rxd_clear  <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      rxd_clear  <= capture;
      rx_overrun <= rx_overrun_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      txd_start <= 1'b0;
      txd_data  <= 8'h00;
    end else begin
      case (state_q)
        IDLE:      if (tx_pop && !lb) begin
                     txd_start <= 1'b1;
                     txd_data  <= tx_head;
                     state_q   <= START;
                   end
        START:     begin
                     txd_start <= 1'b0;
                     state_q   <= WAIT_BUSY;
                   end
        WAIT_BUSY: if (txd_busy) state_q <= WAIT_DONE;
        WAIT_DONE: if (!txd_busy) state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_byte_ctrl.sv
// tb_uart_byte_ctrl: directed self-checking bench for uart_byte_ctrl with a simple transmitter/receiver model.
module tb_uart_byte_ctrl;
  logic       clk = 0, rst_n = 0;
  logic       tx_in_valid = 0, tx_in_ready, rx_out_valid, rx_out_ready = 0;
  logic [7:0] tx_in_data = 0, rx_out_data, txd_data, rxd_data = 0;
  logic       txd_start, txd_busy, rxd_ready = 0, rxd_clear, rx_overrun, overrun_clr = 0;
  logic [4:0] tx_count, rx_count;
  logic       busy_force = 0;
  int         bcnt = 0, clr_cnt = 0, errors = 0, checks = 0, base;
  logic [7:0] mon_q [$];
`ifdef UART_BYTE_CTRL_LOOPBACK_EN
  logic       loopback = 0;
`endif
  uart_byte_ctrl #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_BYTE_CTRL_LOOPBACK_EN
    .loopback(loopback),
`endif
    .tx_in_valid(tx_in_valid), .tx_in_ready(tx_in_ready), .tx_in_data(tx_in_data),
    .rx_out_valid(rx_out_valid), .rx_out_ready(rx_out_ready), .rx_out_data(rx_out_data),
    .txd_start(txd_start), .txd_data(txd_data), .txd_busy(txd_busy),
    .rxd_ready(rxd_ready), .rxd_data(rxd_data), .rxd_clear(rxd_clear),
    .tx_count(tx_count), .rx_count(rx_count), .rx_overrun(rx_overrun), .overrun_clr(overrun_clr)
  );
  always #5 clk = ~clk;
  assign txd_busy = busy_force || bcnt != 0;
  always @(negedge clk) begin
    if (txd_start === 1'b1) begin
      mon_q.push_back(txd_data);
      bcnt <= 20;
    end else if (bcnt != 0) bcnt <= bcnt - 1;
    if (rxd_clear === 1'b1) clr_cnt <= clr_cnt + 1;
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic rx_byte(input logic [7:0] d);
    rxd_data  = d;
    rxd_ready = 1;
    for (int k = 0; k < 10 && rxd_clear !== 1'b1; k++) step(1);
    chk("rx_clear_seen", rxd_clear, 1);
    step(1);
    rxd_ready = 0;
    step(1);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      tx_in_valid  = i[0];
      rxd_ready    = ~i[0];
      rx_out_ready = 1;
      overrun_clr  = i[0];
      tx_in_data   = 8'(i * 37);
      step(1);
    end
    chk("rst_tx_ready", tx_in_ready, 1);
    chk("rst_rx_valid", rx_out_valid, 0);
    chk("rst_start", txd_start, 0);
    chk("rst_txd_data", txd_data, 0);
    chk("rst_clear", rxd_clear, 0);
    chk("rst_tx_count", tx_count, 0);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_overrun", rx_overrun, 0);
    tx_in_valid = 0; rxd_ready = 0; rx_out_ready = 0; overrun_clr = 0;
    rst_n = 1;
    step(2);
    base = mon_q.size();
    tx_in_valid = 1; tx_in_data = 8'h55;
    step(1);
    chk("burst_cnt1", tx_count, 1);
    chk("burst_nostart", txd_start, 0);
    tx_in_data = 8'hA3;
    step(1);
    chk("burst_start1", txd_start, 1);
    chk("burst_data1", txd_data, 8'h55);
    tx_in_data = 8'h0F;
    step(1);
    tx_in_valid = 0;
    chk("burst_pulse1", txd_start, 0);
    chk("burst_cnt2", tx_count, 2);
    for (int k = 0; k < 300 && mon_q.size() - base < 3; k++) step(1);
    step(30);
    chk("burst_nstarts", mon_q.size() - base, 3);
    chk("burst_b0", mon_q[base], 8'h55);
    chk("burst_b1", mon_q[base + 1], 8'hA3);
    chk("burst_b2", mon_q[base + 2], 8'h0F);
    chk("burst_empty", tx_count, 0);
    base = mon_q.size();
    busy_force = 1;
    for (int i = 0; i < 17; i++) begin
      tx_in_valid = 1;
      tx_in_data  = 8'(i);
      step(1);
    end
    tx_in_valid = 0;
    chk("full_ready", tx_in_ready, 0);
    chk("full_count", tx_count, 16);
    chk("full_nostart", mon_q.size() - base, 0);
    busy_force = 0;
    for (int k = 0; k < 800 && mon_q.size() - base < 16; k++) step(1);
    step(40);
    chk("full_nstarts", mon_q.size() - base, 16);
    for (int i = 0; i < 16; i++) chk("full_order", mon_q[base + i], 32'(i));
    base = clr_cnt;
    rxd_data = 8'h7E; rxd_ready = 1;
    step(1);
    chk("rx1_clear", rxd_clear, 1);
    chk("rx1_valid", rx_out_valid, 1);
    chk("rx1_data", rx_out_data, 8'h7E);
    chk("rx1_count", rx_count, 1);
    step(1);
    rxd_ready = 0;
    chk("rx1_clear_off", rxd_clear, 0);
    step(2);
    chk("rx1_single", rx_count, 1);
    chk("rx1_nclr", clr_cnt - base, 1);
    rx_out_ready = 1;
    step(1);
    rx_out_ready = 0;
    chk("rx1_popped", rx_count, 0);
    for (int i = 0; i < 17; i++) rx_byte(8'(8'h80 + i));
    chk("ovr_count", rx_count, 16);
    chk("ovr_flag", rx_overrun, 1);
    chk("ovr_head", rx_out_data, 8'h80);
    rxd_data = 8'hEE; rxd_ready = 1; rx_out_ready = 1;
    step(1);
    rx_out_ready = 0;
    chk("ovr_poppush_cnt", rx_count, 16);
    chk("ovr_poppush_head", rx_out_data, 8'h81);
    step(1);
    rxd_ready = 0;
    step(1);
    overrun_clr = 1;
    step(1);
    overrun_clr = 0;
    chk("ovr_cleared", rx_overrun, 0);
    rxd_data = 8'h55; rxd_ready = 1; overrun_clr = 1;
    step(1);
    overrun_clr = 0;
    chk("ovr_set_wins", rx_overrun, 1);
    step(1);
    rxd_ready = 0;
    step(1);
    for (int i = 0; i < 16; i++) begin
      chk("drain", rx_out_data, i < 15 ? 32'(8'h81 + i) : 32'hEE);
      rx_out_ready = 1;
      step(1);
    end
    rx_out_ready = 0;
    chk("drain_empty", rx_out_valid, 0);
`ifdef UART_BYTE_CTRL_LOOPBACK_EN
    base = mon_q.size();
    loopback = 1;
    tx_in_valid = 1; tx_in_data = 8'h12;
    step(1);
    tx_in_data = 8'h34;
    step(1);
    tx_in_valid = 0;
    step(4);
    chk("lb_count", rx_count, 2);
    chk("lb_d0", rx_out_data, 8'h12);
    rx_out_ready = 1;
    step(1);
    rx_out_ready = 0;
    chk("lb_d1", rx_out_data, 8'h34);
    chk("lb_nostart", mon_q.size() - base, 0);
    loopback = 0;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_byte_ctrl.md
Name: uart_byte_ctrl

Overview:
- Byte-level controller sitting directly upstream of the async transmitter and downstream of the async receiver.
- Buffers outgoing bytes in a TX FIFO and issues one-cycle start pulses to the transmitter, sequenced by its busy flag.
- Drains receiver bytes into an RX FIFO and pulses the receiver's clear input.
- Presents valid/ready byte streams and status to the CPU-side MMIO decoder.

Parameters:
- TX_DEPTH, 16, TX FIFO entries; power of 2, minimum 2.
- RX_DEPTH, 16, RX FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  single clock; same domain as transmitter and receiver.
- rst_n  in  1  synchronous, active-low reset.
- tx_in_valid  in  1  CPU byte offered.
- tx_in_ready  out  1  TX FIFO not full.
- tx_in_data  in  8  byte to send.
- rx_out_valid  out  1  RX FIFO not empty.
- rx_out_ready  in  1  consumer pops head.
- rx_out_data  out  8  RX FIFO head, combinational from storage.
- txd_start  out  1  one-cycle start pulse to transmitter.
- txd_data  out  8  byte presented with txd_start.
- txd_busy  in  1  transmitter busy.
- rxd_ready  in  1  receiver data-ready, sticky until cleared.
- rxd_data  in  8  received byte.
- rxd_clear  out  1  one-cycle clear pulse to receiver.
- tx_count  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy.
- rx_count  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy.
- rx_overrun  out  1  sticky: a received byte was dropped.
- overrun_clr  in  1  clears rx_overrun.

Behaviour:
- Reset (rst_n=0 at posedge): both FIFOs empty, all pointers and counts 0, TX FSM in IDLE.
  - Outputs: txd_start=0, txd_data=0, rxd_clear=0, rx_overrun=0, tx_in_ready=1, rx_out_valid=0.
  - Reset mid-frame abandons the byte in flight; the transmitter finishes it on its own.
- FIFOs: circular, pointers one bit wider than the index so full/empty are distinguishable.
  - Counts update on the cycle after push/pop.
  - Push when full and pop when empty are ignored.
- TX push: tx_in_valid && tx_in_ready. No same-cycle full bypass; tx_in_ready = !tx_full.
- TX FSM (registered outputs):
  - IDLE: if TX FIFO non-empty && !txd_busy, then txd_start<=1, txd_data<=head, pop head, go to START.
  - START: txd_start<=0, go to WAIT_BUSY.
  - WAIT_BUSY: stay until txd_busy==1, then go to WAIT_DONE.
  - WAIT_DONE: stay until txd_busy==0, then go to IDLE.
  - Result: at most one start per frame. Minimum spacing between starts = frame length + 3 cycles.
- RX capture: condition is rxd_ready && !rxd_clear.
  - The guard is required because rxd_ready stays high for the cycle in which clear is asserted.
  - On capture: rxd_clear<=1 for exactly one cycle.
  - If !rx_full, or rx_full && pop in the same cycle: push rxd_data.
  - Otherwise: drop the byte and set rx_overrun<=1.
- Overrun: if capture-overrun and overrun_clr occur in the same cycle, set wins.
- RX pop: rx_out_valid && rx_out_ready. Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Latency:
  - tx_in accepted at cycle N → txd_start high at N+2 when idle (N+1 count visible, N+2 pulse).
  - rxd_ready rises at N → rxd_clear high at N+1, rx_out_valid high at N+1.

Optional Feature:
- Macro UART_BYTE_CTRL_LOOPBACK_EN.
- When defined:
  - Extra input loopback (1 bit).
  - While loopback=1: the TX FSM pops the TX head in IDLE, ignoring txd_busy, and pushes it into the RX FIFO the same cycle.
  - Overrun rules apply to these pushes; txd_start stays 0.
  - Receiver-side capture is suppressed; rxd_ready is left uncleared until loopback=0.
  - Changing loopback outside IDLE takes effect on the next return to IDLE.
- When undefined: no loopback port; behaviour exactly as above.

Test Plan:
- Reset: hold rst_n=0 3 cycles with all inputs toggling → tx_in_ready=1, rx_out_valid=0, txd_start=0, rxd_clear=0, counts 0.
- TX burst: push 0x55,0xA3,0x0F back-to-back, model busy high 20 cycles per start → exactly 3 one-cycle txd_start pulses in order 0x55,0xA3,0x0F; first pulse 2 cycles after first accept.
- TX full: push 17 bytes with txd_busy stuck at 1 → tx_in_ready=0 after 16 accepted, tx_count=16, 17th byte not stored, no txd_start.
- RX single: rxd_ready rises with rxd_data=0x7E, held until clear → one rxd_clear pulse, rx_out_data=0x7E, rx_count=1, no double capture.
- RX overrun: 17 bytes, rx_out_ready=0 → first 16 stored, rx_overrun=1.
  - Then pop + new byte in the same cycle when full → byte stored, count stays 16.
  - Then overrun_clr → rx_overrun=0.
- Loopback (macro on, loopback=1): push 0x12,0x34 → rx_out_data 0x12 then 0x34, txd_start never asserted.
